// File: rtl/axi_common_types_pkg.sv
// Shared types and defaults for the AXI NoC write-path arbiter slice.
//   arb_state_e : arbiter FSM states (explicit legacy encodings)
//   AXI_*       : default sizing (4 masters, 4-bit AWLEN/AWQOS, 4-deep B order FIFO)
//   idx_width   : width of a master index select (min 1 bit)
package axi_common_types_pkg;

  localparam int unsigned AXI_NUM_MASTERS = 4;
  localparam int unsigned AXI_LEN_W       = 4;
  localparam int unsigned AXI_QOS_W       = 4;
  localparam int unsigned AXI_B_DEPTH     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_slave_aw_w_arbiter_if.sv
// Signal bundle between the NUM_MASTERS master-side ports and one slave port
// of the write-path arbiter. Payloads (address, data, response) are muxed
// externally using aw_sel / w_sel / b_sel.
//   modport slave  : arbiter view (drives readies to masters, valids to slave)
//   modport master : environment view (masters + downstream slave)
interface axi_slave_aw_w_arbiter_if
  import axi_common_types_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = AXI_NUM_MASTERS,
  parameter int unsigned LEN_W       = AXI_LEN_W,
  parameter int unsigned QOS_W       = AXI_QOS_W
);
  localparam int unsigned IDX_W = idx_width(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]       m_awvalid;
  logic [NUM_MASTERS*LEN_W-1:0] m_awlen;
  logic [NUM_MASTERS*QOS_W-1:0] m_awqos;
  logic [NUM_MASTERS-1:0]       m_awready;
  logic [NUM_MASTERS-1:0]       m_wvalid;
  logic [NUM_MASTERS-1:0]       m_wlast;
  logic [NUM_MASTERS-1:0]       m_wready;
  logic [NUM_MASTERS-1:0]       m_bvalid;
  logic [NUM_MASTERS-1:0]       m_bready;
  logic                         s_awvalid;
  logic                         s_awready;
  logic                         s_wvalid;
  logic                         s_wlast;
  logic                         s_wready;
  logic                         s_bvalid;
  logic                         s_bready;
  logic [IDX_W-1:0]             aw_sel;
  logic [IDX_W-1:0]             w_sel;
  logic [IDX_W-1:0]             b_sel;
  logic                         wlast_err;

  modport slave (
    input  m_awvalid, m_awlen, m_awqos, m_wvalid, m_wlast, m_bready,
           s_awready, s_wready, s_bvalid,
    output m_awready, m_wready, m_bvalid,
           s_awvalid, s_wvalid, s_wlast, s_bready,
           aw_sel, w_sel, b_sel, wlast_err
  );

  modport master (
    output m_awvalid, m_awlen, m_awqos, m_wvalid, m_wlast, m_bready,
           s_awready, s_wready, s_bvalid,
    input  m_awready, m_wready, m_bvalid,
           s_awvalid, s_wvalid, s_wlast, s_bready,
           aw_sel, w_sel, b_sel, wlast_err
  );

endinterface

// File: rtl/axi_arb_order_fifo.sv
// Synchronous FIFO of master indices recording the order in which write
// bursts were completed, so B responses can be routed back in order.
//   clk/rst   : clock, synchronous active-high reset (empties the FIFO)
//   push/push_data : enqueue a master index
//   pop       : dequeue the head
//   head/empty/count : head entry, empty flag, occupancy (0..DEPTH)
// DEPTH must be a power of two >= 2 (pointers wrap naturally).
module axi_arb_order_fifo #(
  parameter  int unsigned DATA_W = 2,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned CNT_W  = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is only consumed while non-empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  assign head  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/axi_slave_aw_w_arbiter.sv
// Per-slave write-path arbiter: picks one AW requester, forwards its AW then
// all of its W beats to the slave port, and routes each B back in burst order.
// Control only; payload muxes are external and steered by aw_sel/w_sel/b_sel.
//   ACLK   : clock (posedge)
//   ARESET : synchronous active-high reset
//   bus    : axi_slave_aw_w_arbiter_if.slave (master AW/W/B handshakes,
//            slave AW/W/B handshakes, selects, wlast_err pulse)
// Build option: define AXI_ARB_QOS_EN to pick the highest-AWQOS requester
// (ties broken in round-robin order); otherwise pure round-robin and
// m_awqos is ignored.
module axi_slave_aw_w_arbiter
  import axi_common_types_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = AXI_NUM_MASTERS,
  parameter int unsigned LEN_W       = AXI_LEN_W,
  parameter int unsigned QOS_W       = AXI_QOS_W,
  parameter int unsigned B_DEPTH     = AXI_B_DEPTH
) (
  input logic                      ACLK,
  input logic                      ARESET,
  axi_slave_aw_w_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(NUM_MASTERS);
  localparam int unsigned CNT_W = $clog2(B_DEPTH) + 1;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             wlast_err_q, wlast_err_d;

  logic [LEN_W-1:0] awlen_a [NUM_MASTERS];
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  int unsigned      arb_idx;
  logic             beat_last;
  logic             fifo_push, fifo_pop, fifo_empty;
  logic [IDX_W-1:0] fifo_head, b_sel_w;
  logic [CNT_W-1:0] fifo_count;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack_len
    assign awlen_a[g] = bus.m_awlen[g*LEN_W +: LEN_W];
  end

`ifdef AXI_ARB_QOS_EN
  logic [QOS_W-1:0] awqos_a [NUM_MASTERS];
  logic [QOS_W-1:0] best_qos;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack_qos
    assign awqos_a[g] = bus.m_awqos[g*QOS_W +: QOS_W];
  end
`else
  logic unused_qos;
  assign unused_qos = ^bus.m_awqos;
`endif

  // Visit masters in round-robin order starting after rr_q. With QoS, only a
  // strictly higher priority displaces an earlier candidate, so ties fall
  // back to round-robin order.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    arb_idx = 0;
`ifdef AXI_ARB_QOS_EN
    best_qos = '0;
`endif
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      arb_idx = 32'(rr_q) + 1 + i;
      if (arb_idx >= NUM_MASTERS) arb_idx = arb_idx - NUM_MASTERS;
      if (bus.m_awvalid[IDX_W'(arb_idx)]) begin
`ifdef AXI_ARB_QOS_EN
        if (!win_vld || (awqos_a[IDX_W'(arb_idx)] > best_qos)) begin
          win_vld  = 1'b1;
          win_idx  = IDX_W'(arb_idx);
          best_qos = awqos_a[IDX_W'(arb_idx)];
        end
`else
        if (!win_vld) begin
          win_vld = 1'b1;
          win_idx = IDX_W'(arb_idx);
        end
`endif
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    wlast_err_d   = 1'b0;
    fifo_push     = 1'b0;
    beat_last     = (cnt_q == len_q);
    bus.s_awvalid = 1'b0;
    bus.m_awready = '0;
    bus.s_wvalid  = 1'b0;
    bus.s_wlast   = 1'b0;
    bus.m_wready  = '0;
    case (state_q)
      IDLE: begin
        if (win_vld && (fifo_count < CNT_W'(B_DEPTH))) begin
          sel_d   = win_idx;
          state_d = ADDR;
        end
      end
      ADDR: begin
        bus.s_awvalid        = 1'b1;
        bus.m_awready[sel_q] = bus.s_awready;
        if (bus.s_awready) begin
          cnt_d   = '0;
          len_d   = awlen_a[sel_q];
          rr_d    = sel_q;
          state_d = DATA;
        end
      end
      DATA: begin
        bus.s_wvalid        = bus.m_wvalid[sel_q];
        bus.s_wlast         = beat_last;
        bus.m_wready[sel_q] = bus.s_wready;
        if (bus.m_wvalid[sel_q] && bus.s_wready) begin
          // Burst length comes from the latched AWLEN; master WLAST is only checked.
          wlast_err_d = (bus.m_wlast[sel_q] != beat_last);
          if (beat_last) begin
            fifo_push = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    b_sel_w      = fifo_empty ? '0 : fifo_head;
    bus.b_sel    = b_sel_w;
    bus.m_bvalid = '0;
    bus.m_bvalid[b_sel_w] = bus.s_bvalid & ~fifo_empty;
    bus.s_bready = bus.m_bready[b_sel_w] & ~fifo_empty;
    fifo_pop     = bus.s_bvalid & bus.m_bready[b_sel_w] & ~fifo_empty;
  end

  assign bus.aw_sel    = sel_q;
  assign bus.w_sel     = sel_q;
  assign bus.wlast_err = wlast_err_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      rr_q        <= IDX_W'(NUM_MASTERS - 1);
      cnt_q       <= '0;
      len_q       <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  axi_arb_order_fifo #(
    .DATA_W (IDX_W),
    .DEPTH  (B_DEPTH)
  ) u_order_fifo (
    .clk       (ACLK),
    .rst       (ARESET),
    .push      (fifo_push),
    .push_data (sel_q),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_axi_slave_aw_w_arbiter.sv
// Directed self-checking bench for axi_slave_aw_w_arbiter (4 masters,
// 4-bit AWLEN/AWQOS, 4-deep B order FIFO). Inputs change 1 time unit after
// the rising edge; outputs are sampled 1 further unit later.
module tb_axi_slave_aw_w_arbiter;

  logic ACLK = 1'b0;
  logic ARESET;
  int   total = 0;
  int   bad   = 0;

`ifdef AXI_ARB_QOS_EN
  localparam bit QOS_ON = 1'b1;
`else
  localparam bit QOS_ON = 1'b0;
`endif

  always #5 ACLK = ~ACLK;

  axi_slave_aw_w_arbiter_if #(.NUM_MASTERS(4), .LEN_W(4), .QOS_W(4)) bus ();

  axi_slave_aw_w_arbiter #(
    .NUM_MASTERS (4),
    .LEN_W       (4),
    .QOS_W       (4),
    .B_DEPTH     (4)
  ) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_awvalid = '0;
    bus.m_awlen   = '0;
    bus.m_awqos   = '0;
    bus.m_wvalid  = '0;
    bus.m_wlast   = '0;
    bus.m_bready  = '0;
    bus.s_awready = 1'b1;
    bus.s_wready  = 1'b1;
    bus.s_bvalid  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
  endtask

  // Waits (bounded) for s_awvalid, records the select, completes the AW
  // handshake (s_awready assumed 1) and optionally drops the master's request.
  task automatic wait_aw(input logic drop, output logic ok, output logic [1:0] sel,
                         output int lat, output logic [3:0] awr);
    ok = 1'b0; sel = '0; lat = -1; awr = '0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (bus.s_awvalid === 1'b1) begin
        ok = 1'b1; sel = bus.aw_sel; lat = c; awr = bus.m_awready;
        break;
      end
      step();
    end
    if (ok) begin
      step();
      if (drop) bus.m_awvalid[sel] = 1'b0;
    end
  endtask

  // Drives W beats from the current w_sel master until a handshake with
  // s_wlast (bounded). wlast_mask[k] is the master's WLAST on beat k.
  task automatic run_w(input logic toggle, input logic [15:0] wlast_mask,
                       output int beats, output int errs, output int first_err_beat,
                       output int last_idx, output int cycles, output logic steer_ok);
    logic [1:0] sel;
    logic       hs, lst;
    beats = 0; errs = 0; first_err_beat = -1; last_idx = -1; cycles = 0; steer_ok = 1'b1;
    sel = bus.w_sel;
    for (int c = 0; c < 64; c++) begin
      bus.s_wready = toggle ? (c % 2 == 0) : 1'b1;
      bus.m_wvalid = '0;
      bus.m_wvalid[sel] = 1'b1;
      bus.m_wlast = '0;
      bus.m_wlast[sel] = wlast_mask[beats];
      #1;
      if (bus.m_wready !== (bus.s_wready ? (4'b0001 << sel) : 4'b0000) ||
          bus.s_wvalid !== 1'b1) steer_ok = 1'b0;
      hs  = bus.s_wready;
      lst = bus.s_wlast;
      if (hs && lst) last_idx = beats;
      step();
      cycles++;
      if (hs) beats++;
      if (bus.wlast_err === 1'b1) begin
        errs++;
        if (first_err_beat < 0) first_err_beat = beats;
      end
      if (hs && lst) break;
    end
    bus.m_wvalid = '0;
    bus.m_wlast  = '0;
    bus.s_wready = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    ARESET = 1'b1;
    bus.m_awvalid = 4'hF;
    bus.s_bvalid  = 1'b1;
    bus.m_bready  = 4'hF;
    step();
    step();
    total++; if (bus.s_awvalid !== 1'b0) begin bad++; $display("FAIL reset_s_awvalid got=%b exp=0", bus.s_awvalid); end
    total++; if (bus.m_awready !== 4'h0) begin bad++; $display("FAIL reset_m_awready got=%b exp=0000", bus.m_awready); end
    total++; if (bus.s_wvalid !== 1'b0 || bus.m_wready !== 4'h0) begin bad++; $display("FAIL reset_w got=%b/%b exp=0/0000", bus.s_wvalid, bus.m_wready); end
    total++; if (bus.m_bvalid !== 4'h0 || bus.s_bready !== 1'b0) begin bad++; $display("FAIL reset_b got=%b/%b exp=0000/0", bus.m_bvalid, bus.s_bready); end
    total++; if (bus.aw_sel !== 2'd0 || bus.w_sel !== 2'd0 || bus.b_sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d/%0d/%0d exp=0/0/0", bus.aw_sel, bus.w_sel, bus.b_sel); end
    total++; if (bus.wlast_err !== 1'b0) begin bad++; $display("FAIL reset_wlast_err got=%b exp=0", bus.wlast_err); end
    clear_inputs();
    ARESET = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic ok; logic [1:0] sel; int lat; logic [3:0] awr;
    int beats, errs, fe, li, cyc; logic st;
    bus.m_awlen   = 16'h0003;
    bus.m_awvalid = 4'b0001;
    wait_aw(1'b1, ok, sel, lat, awr);
    total++; if (!ok || lat != 1) begin bad++; $display("FAIL single_grant_latency got=%0d exp=1", lat); end
    total++; if (sel !== 2'd0 || awr !== 4'b0001) begin bad++; $display("FAIL single_aw_route got=%0d/%b exp=0/0001", sel, awr); end
    run_w(1'b0, 16'h0008, beats, errs, fe, li, cyc, st);
    total++; if (beats != 4 || li != 3) begin bad++; $display("FAIL single_beats got=%0d last=%0d exp=4 last=3", beats, li); end
    total++; if (errs != 0 || !st) begin bad++; $display("FAIL single_w_steer got err=%0d steer=%b exp err=0 steer=1", errs, st); end
    bus.s_bvalid = 1'b1;
    bus.m_bready = 4'b0001;
    #1;
    total++; if (bus.m_bvalid !== 4'b0001 || bus.b_sel !== 2'd0 || bus.s_bready !== 1'b1) begin bad++; $display("FAIL single_b_route got=%b/%0d/%b exp=0001/0/1", bus.m_bvalid, bus.b_sel, bus.s_bready); end
    step();
    #1;
    total++; if (bus.s_bready !== 1'b0 || bus.m_bvalid !== 4'h0) begin bad++; $display("FAIL single_b_empty got=%b/%b exp=0/0000", bus.s_bready, bus.m_bvalid); end
    bus.s_bvalid = 1'b0;
    bus.m_bready = '0;
  endtask

  task automatic test_backpressure();
    logic ok; logic [1:0] sel; int lat; logic [3:0] awr;
    int beats, errs, fe, li, cyc; logic st;
    bus.m_awlen   = 16'h0070;
    bus.m_awvalid = 4'b0010;
    wait_aw(1'b1, ok, sel, lat, awr);
    total++; if (!ok || sel !== 2'd1) begin bad++; $display("FAIL bp_grant got=%0d exp=1", sel); end
    run_w(1'b1, 16'h0080, beats, errs, fe, li, cyc, st);
    total++; if (beats != 8 || li != 7) begin bad++; $display("FAIL bp_beats got=%0d last=%0d exp=8 last=7", beats, li); end
    total++; if (cyc != 15) begin bad++; $display("FAIL bp_cycles got=%0d exp=15", cyc); end
    total++; if (!st || errs != 0) begin bad++; $display("FAIL bp_steer got steer=%b err=%0d exp steer=1 err=0", st, errs); end
  endtask

  task automatic test_wlast_mismatch();
    logic ok; logic [1:0] sel; int lat; logic [3:0] awr;
    int beats, errs, fe, li, cyc; logic st;
    bus.m_awlen   = 16'h0300;
    bus.m_awvalid = 4'b0100;
    wait_aw(1'b1, ok, sel, lat, awr);
    total++; if (!ok || sel !== 2'd2) begin bad++; $display("FAIL mm_grant got=%0d exp=2", sel); end
    run_w(1'b0, 16'h000A, beats, errs, fe, li, cyc, st);
    total++; if (errs != 1 || fe != 2) begin bad++; $display("FAIL mm_err_pulse got=%0d pulses after beat %0d exp=1 after beat 2", errs, fe); end
    total++; if (beats != 4 || li != 3) begin bad++; $display("FAIL mm_burst_end got=%0d last=%0d exp=4 last=3", beats, li); end
    // B order for the two queued bursts (master 1, then master 2)
    bus.s_bvalid = 1'b1;
    bus.m_bready = 4'hF;
    #1;
    total++; if (bus.b_sel !== 2'd1 || bus.m_bvalid !== 4'b0010) begin bad++; $display("FAIL mm_b_first got=%0d/%b exp=1/0010", bus.b_sel, bus.m_bvalid); end
    step();
    #1;
    total++; if (bus.b_sel !== 2'd2 || bus.m_bvalid !== 4'b0100) begin bad++; $display("FAIL mm_b_second got=%0d/%b exp=2/0100", bus.b_sel, bus.m_bvalid); end
    step();
    bus.s_bvalid = 1'b0;
    bus.m_bready = '0;
  endtask

  task automatic test_contention();
    logic ok; logic [1:0] sel; int lat; logic [3:0] awr;
    int beats, errs, fe, li, cyc; logic st;
    logic [1:0] exp_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    bus.s_bvalid  = 1'b1;
    bus.m_bready  = 4'hF;
    bus.m_awvalid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_aw(1'b0, ok, sel, lat, awr);
      if (k == 4) bus.m_awvalid = '0;
      total++; if (!ok || sel !== exp_order[k]) begin bad++; $display("FAIL rr_grant_%0d got=%0d exp=%0d", k, sel, exp_order[k]); end
      run_w(1'b0, 16'h0001, beats, errs, fe, li, cyc, st);
      total++; if (beats != 1 || errs != 0) begin bad++; $display("FAIL rr_burst_%0d got beats=%0d err=%0d exp beats=1 err=0", k, beats, errs); end
    end
    step();
    step();
    bus.s_bvalid = 1'b0;
    bus.m_bready = '0;
  endtask

  task automatic test_full_fifo();
    logic ok; logic [1:0] sel; int lat; logic [3:0] awr;
    int beats, errs, fe, li, cyc; logic st;
    logic granted;
    logic [1:0] exp_b [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.m_awvalid = 4'b0001 << k;
      wait_aw(1'b1, ok, sel, lat, awr);
      total++; if (!ok || sel !== 2'(k)) begin bad++; $display("FAIL full_fill_%0d got=%0d exp=%0d", k, sel, k); end
      run_w(1'b0, 16'h0001, beats, errs, fe, li, cyc, st);
    end
    bus.m_awvalid = 4'b0001;
    granted = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.s_awvalid !== 1'b0 || bus.m_awready !== 4'h0) granted = 1'b1;
      step();
    end
    total++; if (granted !== 1'b0) begin bad++; $display("FAIL full_no_grant got=%b exp=0", granted); end
    bus.s_bvalid = 1'b1;
    bus.m_bready = 4'hF;
    #1;
    total++; if (bus.b_sel !== 2'd0 || bus.m_bvalid !== 4'b0001 || bus.s_bready !== 1'b1) begin bad++; $display("FAIL full_b0 got=%0d/%b/%b exp=0/0001/1", bus.b_sel, bus.m_bvalid, bus.s_bready); end
    step();
    bus.s_bvalid = 1'b0;
    wait_aw(1'b1, ok, sel, lat, awr);
    total++; if (!ok || sel !== 2'd0) begin bad++; $display("FAIL full_grant_after_pop got ok=%b sel=%0d exp ok=1 sel=0", ok, sel); end
    run_w(1'b0, 16'h0001, beats, errs, fe, li, cyc, st);
    bus.s_bvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (bus.b_sel !== exp_b[k] || bus.m_bvalid !== (4'b0001 << exp_b[k])) begin bad++; $display("FAIL full_b_order_%0d got=%0d/%b exp=%0d", k, bus.b_sel, bus.m_bvalid, exp_b[k]); end
      step();
    end
    #1;
    total++; if (bus.s_bready !== 1'b0 || bus.m_bvalid !== 4'h0) begin bad++; $display("FAIL full_drained got=%b/%b exp=0/0000", bus.s_bready, bus.m_bvalid); end
    bus.s_bvalid = 1'b0;
    bus.m_bready = '0;
  endtask

  task automatic test_qos();
    logic ok; logic [1:0] sel; int lat; logic [3:0] awr;
    int beats, errs, fe, li, cyc; logic st;
    logic [1:0] exp_first, exp_tie;
    do_reset();
    bus.s_bvalid  = 1'b1;
    bus.m_bready  = 4'hF;
    exp_first     = QOS_ON ? 2'd3 : 2'd1;
    exp_tie       = QOS_ON ? 2'd3 : 2'd1;
    bus.m_awqos   = {4'd9, 4'd0, 4'd2, 4'd0};
    bus.m_awvalid = 4'b1010;
    wait_aw(1'b1, ok, sel, lat, awr);
    total++; if (!ok || sel !== exp_first) begin bad++; $display("FAIL qos_priority got=%0d exp=%0d", sel, exp_first); end
    run_w(1'b0, 16'h0001, beats, errs, fe, li, cyc, st);
    wait_aw(1'b1, ok, sel, lat, awr);
    total++; if (!ok || sel !== (2'd3 ^ 2'd1 ^ exp_first)) begin bad++; $display("FAIL qos_second got=%0d exp=%0d", sel, 2'd3 ^ 2'd1 ^ exp_first); end
    run_w(1'b0, 16'h0001, beats, errs, fe, li, cyc, st);
    bus.m_awqos   = {4'd5, 4'd5, 4'd5, 4'd5};
    bus.m_awvalid = 4'b1010;
    wait_aw(1'b1, ok, sel, lat, awr);
    total++; if (!ok || sel !== exp_tie) begin bad++; $display("FAIL qos_tie_rr got=%0d exp=%0d", sel, exp_tie); end
    bus.m_awvalid = '0;
    run_w(1'b0, 16'h0001, beats, errs, fe, li, cyc, st);
    step();
    clear_inputs();
  endtask

  task automatic test_reset_mid_data();
    logic ok; logic [1:0] sel; int lat; logic [3:0] awr;
    int beats, errs, fe, li, cyc; logic st;
    do_reset();
    bus.m_awvalid = 4'b0010;
    wait_aw(1'b1, ok, sel, lat, awr);
    run_w(1'b0, 16'h0001, beats, errs, fe, li, cyc, st);
    bus.m_awlen   = 16'h0700;
    bus.m_awvalid = 4'b0100;
    wait_aw(1'b1, ok, sel, lat, awr);
    bus.m_wvalid  = 4'b0100;
    #1;
    total++; if (bus.s_wvalid !== 1'b1 || bus.w_sel !== 2'd2) begin bad++; $display("FAIL rst_mid_in_data got=%b/%0d exp=1/2", bus.s_wvalid, bus.w_sel); end
    step();
    step();
    ARESET        = 1'b1;
    bus.m_awvalid = 4'hF;
    bus.s_bvalid  = 1'b1;
    bus.m_bready  = 4'hF;
    step();
    total++; if (bus.s_wvalid !== 1'b0 || bus.s_wlast !== 1'b0 || bus.m_wready !== 4'h0 || bus.s_awvalid !== 1'b0 || bus.m_awready !== 4'h0) begin bad++; $display("FAIL rst_mid_aw_w got=%b%b%b%b%b exp=all 0", bus.s_wvalid, bus.s_wlast, bus.m_wready, bus.s_awvalid, bus.m_awready); end
    total++; if (bus.m_bvalid !== 4'h0 || bus.s_bready !== 1'b0 || bus.w_sel !== 2'd0 || bus.b_sel !== 2'd0 || bus.wlast_err !== 1'b0) begin bad++; $display("FAIL rst_mid_b_sel got=%b/%b/%0d/%0d/%b exp=0000/0/0/0/0", bus.m_bvalid, bus.s_bready, bus.w_sel, bus.b_sel, bus.wlast_err); end
    bus.m_awvalid = '0;
    bus.m_wvalid  = '0;
    ARESET        = 1'b0;
    step();
    total++; if (bus.s_bready !== 1'b0 || bus.m_bvalid !== 4'h0) begin bad++; $display("FAIL rst_mid_fifo_empty got=%b/%b exp=0/0000", bus.s_bready, bus.m_bvalid); end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    ARESET = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_wlast_mismatch();
    test_contention();
    test_full_fifo();
    test_qos();
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
